main_sweep_ctrl: RTL
====================

MAIN_SWEEP_CTRL -- requirements
Module: main_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the cycles each input vector is held before the Main output is sampled (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-005 abort  input  1  cancels a running sweep.
REQ-006 f  input  1  combinational output of the Main block under sequencing.
REQ-007 a, b, c, d  output  1 each  drive Main inputs a, b, c, d; {a,b,c,d} = current vector, a is MSB.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse on sweep completion.
REQ-010 truth_table  output  16  bit i holds f sampled with vector i applied.
REQ-011 ones  output  5  count of vectors for which f sampled 1 (0..16).

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, CAPTURE and FINISH.
REQ-013 IDLE with start=1 and abort=0 SHALL clear vec, the settle counter, truth_table and ones, then move to WAIT.
REQ-014 WAIT SHALL increment the settle counter each cycle and move to CAPTURE in the cycle the counter equals SETTLE-1.
REQ-015 CAPTURE SHALL write f into truth_table[vec] and add f to ones.
REQ-016 From CAPTURE, vec=15 SHALL go to FINISH; otherwise vec increments, the counter clears and the FSM returns to WAIT.
REQ-017 FINISH SHALL assert done for exactly one cycle and return to IDLE.
REQ-018 busy SHALL be 1 in WAIT and CAPTURE and 0 in IDLE and FINISH.
REQ-019 Each vector SHALL occupy SETTLE+1 cycles, so done is high in cycle 16*(SETTLE+1)+1 after the start-sampling edge (49 for SETTLE=2).
REQ-020 a, b, c, d SHALL be driven from the registered vec only and stay stable for the whole WAIT and CAPTURE of that vector.
REQ-021 start while not in IDLE SHALL be ignored.
REQ-022 abort in WAIT or CAPTURE SHALL force IDLE on the next edge, with no capture that cycle, no done pulse, and truth_table, ones and vec held.
REQ-023 If start and abort are both high in IDLE, abort SHALL win and the FSM stays in IDLE.
REQ-024 truth_table and ones SHALL hold their last values in IDLE until the next accepted start.
REQ-025 ones SHALL never wrap; 16 SHALL be representable.

Reset
REQ-026 rst=1 SHALL, on the next clk edge, force IDLE, with vec=0 (a=b=c=d=0), settle counter 0, busy=0, done=0, truth_table=16'h0000 and ones=0.
REQ-027 rst SHALL take priority over start and abort in every state, including mid-sweep.

Structure
REQ-028 Shared package main_sweep_pkg SHALL hold the state enumeration, VEC_W=4 and NUM_VEC=16.
REQ-029 The settle counter SHALL be a sub-module named settle_counter, with inputs clear and enable and a terminal-count output; all other logic is in main_sweep_ctrl.

Verification
REQ-030 Main model f=a&b, SETTLE=2, start pulse -> done at cycle 49, truth_table=16'hF000, ones=4.
REQ-031 f tied to 1, SETTLE=1 -> done at cycle 33, truth_table=16'hFFFF, ones=16 with no wrap.
REQ-032 f=a^b^c^d, abort in cycle 10 of the sweep -> IDLE next cycle, no done pulse, only bits 0..2 written (truth_table=16'h0006), ones=2.
REQ-033 start re-pulsed in cycles 5 and 20 of a running sweep -> timing and results identical to a single-start run; start together with abort in IDLE -> busy stays 0.
REQ-034 rst asserted in cycle 30 of a sweep -> next cycle all outputs at reset values; a new start then completes normally with correct results.

Source files
------------

// File: rtl/main_sweep_pkg.sv
// Shared types and constants for the Main-block truth-table sweeper.
package main_sweep_pkg;

    localparam int VEC_W   = 4;           // width of the input vector {a,b,c,d}
    localparam int NUM_VEC = 16;          // number of vectors in one sweep
    localparam int ONES_W  = 5;           // wide enough to hold 16 without wrapping
    localparam int CNT_W   = 4;           // settle counter width (SETTLE up to 15)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        FINISH  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/main_sweep_if.sv
// Bus between the sweep controller and whoever sequences / observes it.
// master: the side that requests sweeps and supplies f; slave: the controller.
interface main_sweep_if
    import main_sweep_pkg::*;
();

    logic                 start;
    logic                 abort;
    logic                 f;
    logic                 a;
    logic                 b;
    logic                 c;
    logic                 d;
    logic                 busy;
    logic                 done;
    logic [NUM_VEC-1:0]   truth_table;
    logic [ONES_W-1:0]    ones;

    modport master (
        output start, abort, f,
        input  a, b, c, d, busy, done, truth_table, ones
    );

    modport slave (
        input  start, abort, f,
        output a, b, c, d, busy, done, truth_table, ones
    );

endinterface

// File: rtl/settle_counter.sv
// Counts the cycles a vector has been held; o_tc flags the last settle cycle.
module settle_counter
    import main_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [CNT_W-1:0] r_count;

    // Clear wins over enable so a new vector always starts from zero.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc = (r_count == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/main_sweep_ctrl.sv
// Steps {a,b,c,d} through all 16 vectors, lets each settle for SETTLE cycles,
// then samples f into the truth table and keeps a running count of ones.
module main_sweep_ctrl
    import main_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    main_sweep_if.slave  bus
);

    sweep_state_t        r_state;
    sweep_state_t        w_state_next;
    logic [VEC_W-1:0]    r_vec;
    logic [VEC_W-1:0]    w_vec_next;
    logic [NUM_VEC-1:0]  r_tt;
    logic [NUM_VEC-1:0]  w_tt_next;
    logic [ONES_W-1:0]   r_ones;
    logic [ONES_W-1:0]   w_ones_next;
    logic                w_cnt_clear;
    logic                w_cnt_en;
    logic                w_cnt_tc;
    logic                w_busy;
    logic                w_done;

    settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_tc     (w_cnt_tc)
    );

    // State and datapath registers; reset overrides everything, including mid-sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_tt    <= '0;
            r_ones  <= '0;
        end else begin
            r_state <= w_state_next;
            r_vec   <= w_vec_next;
            r_tt    <= w_tt_next;
            r_ones  <= w_ones_next;
        end
    end

    // Next-state, datapath updates and Moore outputs; abort always beats start/capture.
    always_comb begin
        w_state_next = r_state;
        w_vec_next   = r_vec;
        w_tt_next    = r_tt;
        w_ones_next  = r_ones;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_vec_next   = '0;
                    w_tt_next    = '0;
                    w_ones_next  = '0;
                    w_cnt_clear  = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_busy = 1'b1;
                if (bus.abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_cnt_tc) begin
                        w_state_next = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                w_busy = 1'b1;
                if (bus.abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_tt_next[r_vec] = bus.f;
                    w_ones_next      = r_ones + ONES_W'(bus.f);
                    w_cnt_clear      = 1'b1;
                    if (r_vec == VEC_W'(NUM_VEC - 1)) begin
                        w_state_next = FINISH;
                    end else begin
                        w_vec_next   = r_vec + VEC_W'(1);
                        w_state_next = WAIT;
                    end
                end
            end
            FINISH: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Main inputs come straight from the registered vector so they never glitch.
    assign bus.a           = r_vec[3];
    assign bus.b           = r_vec[2];
    assign bus.c           = r_vec[1];
    assign bus.d           = r_vec[0];
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.truth_table = r_tt;
    assign bus.ones        = r_ones;

endmodule
